multi_debouncer: RTL and testbench

MULTI_DEBOUNCER -- requirements
Module: multi_debouncer

---
 rtl/multi_debouncer.sv | 118 +++++++++++
 tb/tb_multi_debouncer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/multi_debouncer.sv
// multi_debouncer: per-channel button/switch debouncer with edge pulses
// and optional long-press detection.
//
// Each channel synchronises its raw input through two flops. It then
// requires the synchronised level to differ from the debounced output for
// STABLE_CNT consecutive cycles before the output follows. rise_pulse and
// fall_pulse mark the first cycle in which the new debounced level is seen.
//
// Optional feature: define MULTI_DEBOUNCER_LONG_PRESS_EN to build the
// per-channel hold counters. long_press then pulses once when a channel has
// been debounced-high for LONG_CNT cycles. Without the macro, long_press is
// tied to zero and no hold counters exist.

module multi_debouncer #(
  parameter int CHANNELS   = 4,
  parameter int STABLE_CNT = 1024,
  parameter int LONG_CNT   = 65536,
  parameter bit INIT_LEVEL = 1'b0
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [CHANNELS-1:0] btn_in,
  output logic [CHANNELS-1:0] db_out,
  output logic [CHANNELS-1:0] rise_pulse,
  output logic [CHANNELS-1:0] fall_pulse,
  output logic [CHANNELS-1:0] long_press
);

  localparam int SCW = $clog2(STABLE_CNT) + 1;
  localparam logic [SCW-1:0] STABLE_LAST = SCW'(STABLE_CNT - 1);
  localparam logic [CHANNELS-1:0] INIT_VEC = {CHANNELS{INIT_LEVEL}};

  // Reject parameter values the counters are not sized or intended for.
  if (CHANNELS < 1 || CHANNELS > 32) begin : g_bad_channels
    $error("multi_debouncer: CHANNELS out of range 1..32");
  end
  if (STABLE_CNT < 2 || STABLE_CNT > (1 << 20)) begin : g_bad_stable_cnt
    $error("multi_debouncer: STABLE_CNT out of range 2..2^20");
  end
  if (LONG_CNT < 2 || LONG_CNT > (1 << 24)) begin : g_bad_long_cnt
    $error("multi_debouncer: LONG_CNT out of range 2..2^24");
  end

  logic [CHANNELS-1:0] s1;
  logic [CHANNELS-1:0] s2;
  logic [SCW-1:0]      stab_cnt [CHANNELS];

  // Two-flop synchroniser; reset loads the idle level so no false edge follows reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1 <= INIT_VEC;
      s2 <= INIT_VEC;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  // Per-channel stability counter; the output follows only after an unbroken run of the new level.
  always_ff @(posedge clk) begin
    if (reset) begin
      db_out     <= INIT_VEC;
      rise_pulse <= '0;
      fall_pulse <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        stab_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        rise_pulse[i] <= 1'b0;
        fall_pulse[i] <= 1'b0;
        if (s2[i] == db_out[i]) begin
          stab_cnt[i] <= '0;
        end else if (stab_cnt[i] == STABLE_LAST) begin
          db_out[i]     <= s2[i];
          stab_cnt[i]   <= '0;
          rise_pulse[i] <= s2[i];
          fall_pulse[i] <= ~s2[i];
        end else begin
          stab_cnt[i] <= stab_cnt[i] + SCW'(1);
        end
      end
    end
  end

`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
  localparam int HCW = $clog2(LONG_CNT) + 1;
  localparam logic [HCW-1:0] HOLD_MAX  = HCW'(LONG_CNT);
  localparam logic [HCW-1:0] HOLD_LAST = HCW'(LONG_CNT - 1);

  logic [HCW-1:0] hold_cnt [CHANNELS];

  // Hold counter saturates at LONG_CNT, so the long-press pulse fires once per press.
  always_ff @(posedge clk) begin
    if (reset) begin
      long_press <= '0;
      for (int i = 0; i < CHANNELS; i++) begin
        hold_cnt[i] <= '0;
      end
    end else begin
      for (int i = 0; i < CHANNELS; i++) begin
        long_press[i] <= 1'b0;
        if (!db_out[i]) begin
          hold_cnt[i] <= '0;
        end else if (hold_cnt[i] != HOLD_MAX) begin
          hold_cnt[i] <= hold_cnt[i] + HCW'(1);
          if (hold_cnt[i] == HOLD_LAST) begin
            long_press[i] <= 1'b1;
          end
        end
      end
    end
  end
`else
  assign long_press = '0;
`endif

endmodule

// File: tb/tb_multi_debouncer.sv
// tb_multi_debouncer: directed test of multi_debouncer with CHANNELS=4,
// STABLE_CNT=8 and LONG_CNT=32. The long-press expectations depend on
// whether MULTI_DEBOUNCER_LONG_PRESS_EN is defined.
//
// Edge numbering: inputs change 1 time unit after a rising edge. "Edge e"
// is the e-th rising edge after that change. Outputs are sampled 1 time
// unit after each edge.

module tb_multi_debouncer;

  localparam int CH = 4;
  localparam int SC = 8;
  localparam int LC = 32;
`ifdef MULTI_DEBOUNCER_LONG_PRESS_EN
  localparam bit LP_EN = 1'b1;
`else
  localparam bit LP_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [CH-1:0] btn_in = '0;
  logic [CH-1:0] db_out;
  logic [CH-1:0] rise_pulse;
  logic [CH-1:0] fall_pulse;
  logic [CH-1:0] long_press;

  int checks = 0;
  int errors = 0;

  multi_debouncer #(
    .CHANNELS  (CH),
    .STABLE_CNT(SC),
    .LONG_CNT  (LC),
    .INIT_LEVEL(1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_in    (btn_in),
    .db_out    (db_out),
    .rise_pulse(rise_pulse),
    .fall_pulse(fall_pulse),
    .long_press(long_press)
  );

  always #5 clk = ~clk;

  // Stop a runaway simulation.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset  = 1'b1;
    btn_in = '0;
    repeat (3) tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    btn_in = 4'b1111;
    repeat (4) tick();
    checks++; if (db_out !== 4'b0000) begin errors++; $display("[TB] FAIL reset db_out: got %b expected 0000", db_out); end
    checks++; if (rise_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL reset rise_pulse: got %b expected 0000", rise_pulse); end
    checks++; if (fall_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL reset fall_pulse: got %b expected 0000", fall_pulse); end
    checks++; if (long_press !== 4'b0000) begin errors++; $display("[TB] FAIL reset long_press: got %b expected 0000", long_press); end
  endtask

  task automatic test_single_rise_fall();
    logic [CH-1:0] exp_db, exp_rise, exp_fall;
    do_reset();
    btn_in = 4'b0001;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_db   = (e >= 10) ? 4'b0001 : 4'b0000;
      exp_rise = (e == 10) ? 4'b0001 : 4'b0000;
      checks++; if (db_out !== exp_db) begin errors++; $display("[TB] FAIL rise db_out e=%0d: got %b expected %b", e, db_out, exp_db); end
      checks++; if (rise_pulse !== exp_rise) begin errors++; $display("[TB] FAIL rise rise_pulse e=%0d: got %b expected %b", e, rise_pulse, exp_rise); end
      checks++; if (fall_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL rise fall_pulse e=%0d: got %b expected 0000", e, fall_pulse); end
    end
    btn_in = 4'b0000;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_db   = (e >= 10) ? 4'b0000 : 4'b0001;
      exp_fall = (e == 10) ? 4'b0001 : 4'b0000;
      checks++; if (db_out !== exp_db) begin errors++; $display("[TB] FAIL fall db_out e=%0d: got %b expected %b", e, db_out, exp_db); end
      checks++; if (fall_pulse !== exp_fall) begin errors++; $display("[TB] FAIL fall fall_pulse e=%0d: got %b expected %b", e, fall_pulse, exp_fall); end
      checks++; if (rise_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL fall rise_pulse e=%0d: got %b expected 0000", e, rise_pulse); end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      if (e <= 5 || (e >= 7 && e <= 11)) btn_in = 4'b0010;
      else btn_in = 4'b0000;
      tick();
      checks++; if (db_out !== 4'b0000) begin errors++; $display("[TB] FAIL glitch db_out e=%0d: got %b expected 0000", e, db_out); end
      checks++; if ((rise_pulse | fall_pulse) !== 4'b0000) begin errors++; $display("[TB] FAIL glitch pulses e=%0d: got %b/%b expected 0000/0000", e, rise_pulse, fall_pulse); end
    end
  endtask

  task automatic test_threshold();
    logic [CH-1:0] exp_db, exp_rise, exp_fall;
    // Seven cycles high is one short of the threshold.
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      btn_in = (e <= 7) ? 4'b0001 : 4'b0000;
      tick();
      checks++; if (db_out !== 4'b0000) begin errors++; $display("[TB] FAIL thr7 db_out e=%0d: got %b expected 0000", e, db_out); end
      checks++; if (rise_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL thr7 rise_pulse e=%0d: got %b expected 0000", e, rise_pulse); end
    end
    // Eight cycles high is exactly enough; the low level then takes the full latency too.
    do_reset();
    for (int e = 1; e <= 22; e++) begin
      btn_in = (e <= 8) ? 4'b0001 : 4'b0000;
      tick();
      exp_db   = (e >= 10 && e < 18) ? 4'b0001 : 4'b0000;
      exp_rise = (e == 10) ? 4'b0001 : 4'b0000;
      exp_fall = (e == 18) ? 4'b0001 : 4'b0000;
      checks++; if (db_out !== exp_db) begin errors++; $display("[TB] FAIL thr8 db_out e=%0d: got %b expected %b", e, db_out, exp_db); end
      checks++; if (rise_pulse !== exp_rise) begin errors++; $display("[TB] FAIL thr8 rise_pulse e=%0d: got %b expected %b", e, rise_pulse, exp_rise); end
      checks++; if (fall_pulse !== exp_fall) begin errors++; $display("[TB] FAIL thr8 fall_pulse e=%0d: got %b expected %b", e, fall_pulse, exp_fall); end
    end
  endtask

  task automatic test_long_press();
    logic [CH-1:0] exp_db, exp_rise, exp_fall, exp_long;
    do_reset();
    btn_in = 4'b0100;
    for (int e = 1; e <= 50; e++) begin
      tick();
      exp_db   = (e >= 10) ? 4'b0100 : 4'b0000;
      exp_rise = (e == 10) ? 4'b0100 : 4'b0000;
      exp_long = (LP_EN && e == 10 + LC) ? 4'b0100 : 4'b0000;
      checks++; if (db_out !== exp_db) begin errors++; $display("[TB] FAIL long db_out e=%0d: got %b expected %b", e, db_out, exp_db); end
      checks++; if (rise_pulse !== exp_rise) begin errors++; $display("[TB] FAIL long rise_pulse e=%0d: got %b expected %b", e, rise_pulse, exp_rise); end
      checks++; if (long_press !== exp_long) begin errors++; $display("[TB] FAIL long long_press e=%0d: got %b expected %b", e, long_press, exp_long); end
    end
    btn_in = 4'b0000;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_db   = (e >= 10) ? 4'b0000 : 4'b0100;
      exp_fall = (e == 10) ? 4'b0100 : 4'b0000;
      checks++; if (db_out !== exp_db) begin errors++; $display("[TB] FAIL long_rel db_out e=%0d: got %b expected %b", e, db_out, exp_db); end
      checks++; if (fall_pulse !== exp_fall) begin errors++; $display("[TB] FAIL long_rel fall_pulse e=%0d: got %b expected %b", e, fall_pulse, exp_fall); end
      checks++; if (long_press !== 4'b0000) begin errors++; $display("[TB] FAIL long_rel long_press e=%0d: got %b expected 0000", e, long_press); end
    end
  endtask

  task automatic test_back_to_back();
    logic [CH-1:0] exp_db, exp_rise, exp_fall;
    do_reset();
    btn_in = 4'b1111;
    for (int e = 1; e <= 20; e++) begin
      tick();
      exp_db   = (e >= 10) ? 4'b1111 : 4'b0000;
      exp_rise = (e == 10) ? 4'b1111 : 4'b0000;
      checks++; if (db_out !== exp_db) begin errors++; $display("[TB] FAIL all_rise db_out e=%0d: got %b expected %b", e, db_out, exp_db); end
      checks++; if (rise_pulse !== exp_rise) begin errors++; $display("[TB] FAIL all_rise rise_pulse e=%0d: got %b expected %b", e, rise_pulse, exp_rise); end
      checks++; if (long_press !== 4'b0000) begin errors++; $display("[TB] FAIL all_rise long_press e=%0d: got %b expected 0000", e, long_press); end
    end
    btn_in = 4'b0000;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_db   = (e >= 10) ? 4'b0000 : 4'b1111;
      exp_fall = (e == 10) ? 4'b1111 : 4'b0000;
      checks++; if (db_out !== exp_db) begin errors++; $display("[TB] FAIL all_fall db_out e=%0d: got %b expected %b", e, db_out, exp_db); end
      checks++; if (fall_pulse !== exp_fall) begin errors++; $display("[TB] FAIL all_fall fall_pulse e=%0d: got %b expected %b", e, fall_pulse, exp_fall); end
      checks++; if (rise_pulse !== 4'b0000) begin errors++; $display("[TB] FAIL all_fall rise_pulse e=%0d: got %b expected 0000", e, rise_pulse); end
    end
  endtask

  task automatic test_reset_mid_count();
    logic [CH-1:0] exp_db, exp_rise;
    do_reset();
    btn_in = 4'b1000;
    repeat (7) tick();
    reset = 1'b1;
    for (int r = 1; r <= 3; r++) begin
      tick();
      checks++; if (db_out !== 4'b0000) begin errors++; $display("[TB] FAIL mid_reset db_out r=%0d: got %b expected 0000", r, db_out); end
      checks++; if ((rise_pulse | fall_pulse | long_press) !== 4'b0000) begin errors++; $display("[TB] FAIL mid_reset pulses r=%0d: got %b expected 0000", r, rise_pulse | fall_pulse | long_press); end
    end
    reset = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      tick();
      exp_db   = (e >= 10) ? 4'b1000 : 4'b0000;
      exp_rise = (e == 10) ? 4'b1000 : 4'b0000;
      checks++; if (db_out !== exp_db) begin errors++; $display("[TB] FAIL post_reset db_out e=%0d: got %b expected %b", e, db_out, exp_db); end
      checks++; if (rise_pulse !== exp_rise) begin errors++; $display("[TB] FAIL post_reset rise_pulse e=%0d: got %b expected %b", e, rise_pulse, exp_rise); end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    $display("[TB] multi_debouncer test start, long press %0s", LP_EN ? "enabled" : "disabled");
    test_reset();
    test_single_rise_fall();
    test_glitch();
    test_threshold();
    test_long_press();
    test_back_to_back();
    test_reset_mid_count();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
